// File: rtl/sweep_pkg.sv
// Shared constants, types and state encoding for the sine/cosine angle sweeper.
package sweep_pkg;

    localparam int ANGLE_W = 32'd10;   // Q3.7 angle, matches the sine ROM address
    localparam int DATA_W  = 32'd16;   // Q2.14 sample, matches the sine ROM output
    localparam int CNT_W   = 32'd10;   // sample count / index width

    // One bit wider than an angle so a raw angle sum can be compared against it.
    localparam logic [ANGLE_W:0]   TWO_PI  = 11'd804;   // round(2*pi*128)
    localparam logic [ANGLE_W-1:0] HALF_PI = 10'd201;   // round(pi/2*128)

    typedef logic [ANGLE_W-1:0]        angle_t;
    typedef logic signed [DATA_W-1:0]  sample_t;
    typedef logic [CNT_W-1:0]          cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // An angle is usable only if it already lies in [0, TWO_PI).
    function automatic logic angle_legal(input angle_t a);
        return ({1'b0, a} < TWO_PI);
    endfunction

endpackage

// File: rtl/angle_wrap_add.sv
// Combinational a + b modulo TWO_PI for operands already in [0, TWO_PI).
module angle_wrap_add
    import sweep_pkg::*;
(
    input  logic [ANGLE_W-1:0] i_a,
    input  logic [ANGLE_W-1:0] i_b,
    output logic [ANGLE_W-1:0] o_sum
);

    // The wrapped result is always below TWO_PI, so the subtraction can be done
    // in ANGLE_W bits and still come out right modulo 2^ANGLE_W.
    localparam logic [ANGLE_W-1:0] TWO_PI_LO = TWO_PI[ANGLE_W-1:0];

    logic [ANGLE_W:0]   w_sum;
    logic [ANGLE_W-1:0] w_sub;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = w_sum[ANGLE_W-1:0] - TWO_PI_LO;

    // Select the raw or the wrapped sum.
    always_comb begin
        o_sum = w_sum[ANGLE_W-1:0];
        if (w_sum >= TWO_PI) begin
            o_sum = w_sub;
        end else begin
            o_sum = w_sum[ANGLE_W-1:0];
        end
    end

endmodule

// File: rtl/sin_cos_sweep.sv
// Angle sequencer feeding two sine ROM instances (theta and theta + pi/2) and
// streaming the returned (sin, cos, index) samples over valid/ready.
module sin_cos_sweep
    import sweep_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ANGLE_W-1:0] step,
    input  logic [ANGLE_W-1:0] phase0,
    input  logic [CNT_W-1:0]   num_samples,
    output logic [ANGLE_W-1:0] theta_sin,
    output logic [ANGLE_W-1:0] theta_cos,
    input  logic [DATA_W-1:0]  sin_rom,
    input  logic [DATA_W-1:0]  cos_rom,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sin,
    output logic [DATA_W-1:0]  out_cos,
    output logic [CNT_W-1:0]   out_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t  r_state, w_state_nxt;
    angle_t  r_phase, r_theta_cos, r_step;
    cnt_t    r_remaining, r_idx, r_out_idx;
    sample_t r_out_sin, r_out_cos;
    logic    r_addr_fresh, r_out_valid, r_busy, r_done, r_err;

    angle_t  w_phase_adv, w_phase_nxt, w_cos_nxt;
    logic    w_slot_free, w_pop;
    logic    w_accept, w_reject, w_empty_run, w_capture, w_finish;

    assign w_pop       = r_out_valid & out_ready;
    assign w_slot_free = ~r_out_valid | out_ready;

    angle_wrap_add u_phase_adv (.i_a(r_phase),     .i_b(r_step),  .o_sum(w_phase_adv));
    angle_wrap_add u_cos_ofs   (.i_a(w_phase_nxt), .i_b(HALF_PI), .o_sum(w_cos_nxt));

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_empty_run = 1'b0;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!angle_legal(step) || !angle_legal(phase0)) begin
                        w_reject = 1'b1;
                    end else if (num_samples == '0) begin
                        w_empty_run = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                // ROM data is only trusted one cycle after the address moved.
                if (r_addr_fresh && w_slot_free) begin
                    w_capture = 1'b1;
                    if (r_remaining == cnt_t'(1'b1)) begin
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (w_pop) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FLUSH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Phase source: start angle on accept, advanced angle on capture, else hold.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_accept) begin
            w_phase_nxt = phase0;
        end else if (w_capture) begin
            w_phase_nxt = w_phase_adv;
        end else begin
            w_phase_nxt = r_phase;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep counters, ROM addresses and the settle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= '0;
            r_theta_cos  <= '0;
            r_step       <= '0;
            r_remaining  <= '0;
            r_idx        <= '0;
            r_addr_fresh <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_theta_cos <= w_cos_nxt;
            if (w_accept) begin
                r_step       <= step;
                r_remaining  <= num_samples;
                r_idx        <= '0;
                r_addr_fresh <= 1'b0;
            end else if (w_capture) begin
                r_remaining  <= r_remaining - cnt_t'(1'b1);
                r_idx        <= r_idx + cnt_t'(1'b1);
                r_addr_fresh <= 1'b0;
            end else if (r_state == RUN) begin
                r_addr_fresh <= 1'b1;
            end
        end
    end

    // Output sample slot and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sin   <= '0;
            r_out_cos   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_out_sin   <= sin_rom;
                r_out_cos   <= cos_rom;
                r_out_idx   <= r_idx;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (w_accept || w_empty_run) begin
                r_err <= 1'b0;
            end
            r_done <= w_empty_run | w_finish;
            r_busy <= (w_state_nxt != IDLE);
        end
    end

    assign theta_sin = r_phase;
    assign theta_cos = r_theta_cos;
    assign out_sin   = r_out_sin;
    assign out_cos   = r_out_cos;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_sin_cos_sweep.sv
// Scoreboard bench for sin_cos_sweep with a settling sine ROM model.
module tb_sin_cos_sweep;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [9:0]         step = 10'd0;
    logic [9:0]         phase0 = 10'd0;
    logic [9:0]         num_samples = 10'd0;
    logic [9:0]         theta_sin, theta_cos;
    logic signed [15:0] sin_rom, cos_rom;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_sin, out_cos;
    logic [9:0]         out_idx;
    logic               busy, done, err;

    sin_cos_sweep dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .phase0(phase0),
        .num_samples(num_samples), .theta_sin(theta_sin), .theta_cos(theta_cos),
        .sin_rom(sin_rom), .cos_rom(cos_rom), .out_valid(out_valid),
        .out_ready(out_ready), .out_sin(out_sin), .out_cos(out_cos),
        .out_idx(out_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Ideal Q2.14 sine of a Q3.7 angle.
    function automatic logic signed [15:0] rom_val(input int th);
        real r;
        r = $sin(real'(th) / 128.0) * 16384.0;
        if (r >= 0.0) return 16'($rtoi(r + 0.5));
        else          return 16'($rtoi(r - 0.5));
    endfunction

    // ROM model: data is garbage in the cycle right after the address changes.
    logic [9:0] prev_sin = 10'd0, prev_cos = 10'd0;
    always @(posedge clk) begin
        prev_sin <= theta_sin;
        prev_cos <= theta_cos;
    end
    always_comb begin
        sin_rom = (theta_sin == prev_sin) ? rom_val(int'(theta_sin)) : 16'sh5A5A;
        cos_rom = (theta_cos == prev_cos) ? rom_val(int'(theta_cos)) : 16'sh5A5A;
    end

    typedef struct {
        int s;
        int c;
        int i;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0, errors = 0;
    int done_cnt = 0, valid_cnt = 0;
    int bp_hold = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: sample k is at (phase0 + k*step) mod 2pi, cosine a quarter turn on.
    task automatic push_run(input int p0, input int st, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int th;
            th = (p0 + k * st) % 804;
            e.s = int'(rom_val(th));
            e.c = int'(rom_val((th + 201) % 804));
            e.i = k;
            sb_q.push_back(e);
        end
    endtask

    // Ready driver: forced low while bp_hold runs, otherwise high or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold > 0) begin
                out_ready = 1'b0;
                bp_hold--;
            end else if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: stream stability, scoreboard pop on handshake, done pulse width.
    initial begin
        bit stall_prev = 1'b0, prev_done = 1'b0;
        int hs = 0, hc = 0, hi = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_sin", int'(out_sin), hs);
                    check("hold_cos", int'(out_cos), hc);
                    check("hold_idx", int'(out_idx), hi);
                end
                if (out_valid) valid_cnt++;
                if (out_valid && out_ready) begin
                    check("sb_nonempty", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sample_sin", int'(out_sin), e.s);
                        check("sample_cos", int'(out_cos), e.c);
                        check("sample_idx", int'(out_idx), e.i);
                    end
                end
                stall_prev = out_valid && !out_ready;
                hs = int'(out_sin);
                hc = int'(out_cos);
                hi = int'(out_idx);
                if (done) begin
                    done_cnt++;
                    check("done_width", int'(prev_done), 0);
                end
                prev_done = done;
            end
        end
    end

    // Pulse start for one cycle; returns 2 time units after the accepting edge.
    task automatic do_start(input int p0, input int st, input int n);
        @(posedge clk);
        #2;
        phase0      = 10'(p0);
        step        = 10'(st);
        num_samples = 10'(n);
        start       = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("idle_timeout", int'(n < 3000), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic run(input int p0, input int st, input int n);
        int d0;
        d0 = done_cnt;
        push_run(p0, st, n);
        do_start(p0, st, n);
        wait_idle();
        check("done_count", done_cnt - d0, 1);
        check("sb_drained", sb_q.size(), 0);
        check("busy_after", int'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_theta_sin"}, int'(theta_sin), 0);
        check({tag, "_theta_cos"}, int'(theta_cos), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_sin"}, int'(out_sin), 0);
        check({tag, "_cos"}, int'(out_cos), 0);
        check({tag, "_idx"}, int'(out_idx), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        int d0, v0, n;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Quarter-turn sweep.
        run(0, 201, 4);

        // Wrap across 2pi.
        d0 = done_cnt;
        push_run(800, 10, 2);
        do_start(800, 10, 2);
        check("wrap_theta_sin", int'(theta_sin), 800);
        check("wrap_theta_cos", int'(theta_cos), 197);
        wait_idle();
        check("wrap_done", done_cnt - d0, 1);
        check("wrap_drained", sb_q.size(), 0);

        // Backpressure on the first sample.
        d0 = done_cnt;
        push_run(123, 77, 6);
        do_start(123, 77, 6);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("bp_first_valid", int'(out_valid), 1);
        out_ready = 1'b0;
        bp_hold   = 5;
        wait_idle();
        check("bp_done", done_cnt - d0, 1);
        check("bp_drained", sb_q.size(), 0);

        // Illegal parameters, then a legal start clears err.
        do_start(0, 804, 3);
        check("illegal_step_err", int'(err), 1);
        check("illegal_step_busy", int'(busy), 0);
        do_start(850, 5, 3);
        check("illegal_phase_err", int'(err), 1);
        check("illegal_phase_busy", int'(busy), 0);
        d0 = done_cnt;
        push_run(10, 20, 3);
        do_start(10, 20, 3);
        check("legal_err_clear", int'(err), 0);
        check("legal_busy", int'(busy), 1);
        wait_idle();
        check("legal_done", done_cnt - d0, 1);
        check("legal_drained", sb_q.size(), 0);

        // Empty run: done one cycle after start, no samples.
        d0 = done_cnt;
        v0 = valid_cnt;
        do_start(5, 5, 0);
        check("zero_done_high", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        @(posedge clk);
        #2;
        check("zero_done_low", int'(done), 0);
        repeat (5) @(posedge clk);
        #2;
        check("zero_done_count", done_cnt - d0, 1);
        check("zero_no_valid", valid_cnt - v0, 0);

        // Reset in the middle of a run.
        push_run(100, 37, 10);
        do_start(100, 37, 10);
        n = 0;
        while (!(out_valid && out_idx == 10'd2) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("midrun_reach_idx2", int'(out_idx), 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun");
        sb_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("midrun_no_done", done_cnt - d0, 0);
        check("midrun_idle_busy", int'(busy), 0);
        check("midrun_idle_valid", int'(out_valid), 0);

        // Randomised sweeps with random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 803)), int'($urandom_range(0, 803)),
                int'($urandom_range(1, 12)));
        end
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
